tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Four-channel time-division demultiplexer: the receiving end of a 4:1 channel multiplexer. It takes a word stream where each frame is four consecutive valid words (slot 0 flagged by `in_sof`) and distributes slots 0..3 onto four registered channel outputs. A frame updates all four channels at once, and only when it is complete. Framing violations are flagged and counted. It sits downstream of the 4:1 mux/serializer, in front of the per-channel consumers.

## Interface
- `W`, default 8: channel word width.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  `in_data` and `in_sof` are meaningful this cycle.
- `in_sof`  in  1  start of frame; marks the word as slot 0. Qualified by `in_valid`.
- `in_data`  in  W  slot word.
- `ch0`, `ch1`, `ch2`, `ch3`  out  W each  last complete frame's slot 0..3 words, registered.
- `out_valid`  out  1  one-cycle pulse; `ch0..ch3` were just updated.
- `frame_err`  out  1  one-cycle pulse; a framing violation was detected.
- `err_cnt`  out  8  saturating count of `frame_err` pulses.

## Operation
- Reset (`rst` high at an edge):
  - State goes to HUNT and the slot counter to 0.
  - Shadow registers and `ch0..ch3` clear to 0.
  - `out_valid`, `frame_err` and `err_cnt` clear to 0.
  - `rst` overrides every other input in the same cycle.
- Internal storage: a 2-bit slot counter `slot` and three W-bit shadow registers `sh0..sh2` that hold the partial frame.
- HUNT state:
  - `in_valid & in_sof`: `sh0 <= in_data`, `slot <= 1`, go to RECV.
  - `in_valid & !in_sof`: word discarded; no error flagged, no state change.
  - `!in_valid`: no action.
- RECV state:
  - `in_valid & !in_sof` with `slot` = 1 or 2: `sh[slot] <= in_data`, then `slot` increments.
  - `in_valid & !in_sof` with `slot` = 3: commit. `ch0..ch2 <= sh0..sh2`, `ch3 <= in_data`, `out_valid <= 1`, `slot <= 0`, go to HUNT.
  - `in_valid & in_sof` (early SOF): the partial frame is discarded and the new word is treated as slot 0. `frame_err <= 1`, `sh0 <= in_data`, `slot <= 1`, stay in RECV.
  - `!in_valid`: hold everything. Gaps of any length between slots are legal.
- An SOF arriving on the cycle right after a commit is normal back-to-back operation. It is handled by HUNT and is not an error.
- `ch0..ch3` change only on a commit edge or on reset. A partial or aborted frame never disturbs them.
- `err_cnt` increments by 1 on every edge where `frame_err` is set. It saturates at 255 and never wraps.
- `out_valid` and `frame_err` are both 0 on any edge without the corresponding event. They are never both 1 in the same cycle.

## Timing
- Latency: slot 3 is sampled at edge N. At edge N the new `ch0..ch3` values appear together with `out_valid` = 1, and they are visible during cycle N→N+1.
- `out_valid` is high for exactly one cycle per committed frame.
- `frame_err` rises at the same edge that samples the offending SOF and is high for one cycle. `err_cnt` reflects the new count at that same edge.
- Throughput: one frame every 4 valid cycles, with no dead cycles required between frames.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Reset mid-frame: the partial frame is lost. The next frame must begin with an SOF.

## Test plan
- Reset, then 4 consecutive valid words A1,B2,C3,D4 (SOF on A1, W=8):
  - `ch0..ch3` = 0xA1,0xB2,0xC3,0xD4 and `out_valid` pulses once, 1 cycle after D4.
  - `frame_err` stays 0.
- Two back-to-back frames 01..04 then 11..14:
  - Two `out_valid` pulses, 4 cycles apart.
  - Final channels = 0x11..0x14.
- Frame with `in_valid` gaps of 0, 3 and 7 idle cycles between slots: same result as the gapless frame, with a single `out_valid`.
- Early SOF:
  - Send SOF 0x10, 0x20, then SOF 0x30,0x40,0x50,0x60.
  - `frame_err` pulses on the 0x30 edge and `err_cnt` = 1.
  - The channels first hold their prior values, then become 0x30..0x60.
- Non-SOF words in HUNT after reset (0xEE ×3), then a valid frame:
  - The stray words are ignored with no error.
  - Channels = the frame's words.
- Reset asserted after slot 2 of a frame:
  - All outputs are 0 the next cycle.
  - Slot-3/slot-0 words sent without SOF produce no `out_valid`.
  - Separately, 300 early SOFs leave `err_cnt` = 255.

Source files
------------

// File: rtl/tdm_demux4.sv
// tdm_demux4: receiving end of a 4:1 channel multiplexer.
// Collects four consecutive valid words (slot 0 flagged by in_sof) into
// shadow registers and commits a whole frame to the four channel outputs
// at once. Early SOFs abort the partial frame, pulse frame_err and bump a
// saturating error counter.
module tdm_demux4 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         in_sof,
    input  logic [W-1:0] in_data,
    output logic [W-1:0] ch0,
    output logic [W-1:0] ch1,
    output logic [W-1:0] ch2,
    output logic [W-1:0] ch3,
    output logic         out_valid,
    output logic         frame_err,
    output logic [7:0]   err_cnt
);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   slot_q, slot_d;
    logic [W-1:0] sh0_q, sh0_d;
    logic [W-1:0] sh1_q, sh1_d;
    logic [W-1:0] sh2_q, sh2_d;
    logic [W-1:0] ch0_q, ch0_d;
    logic [W-1:0] ch1_q, ch1_d;
    logic [W-1:0] ch2_q, ch2_d;
    logic [W-1:0] ch3_q, ch3_d;
    logic         out_valid_q, out_valid_d;
    logic         frame_err_q, frame_err_d;
    logic [7:0]   err_cnt_q, err_cnt_d;

    // State, shadow, channel and status registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            slot_q      <= '0;
            sh0_q       <= '0;
            sh1_q       <= '0;
            sh2_q       <= '0;
            ch0_q       <= '0;
            ch1_q       <= '0;
            ch2_q       <= '0;
            ch3_q       <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            sh0_q       <= sh0_d;
            sh1_q       <= sh1_d;
            sh2_q       <= sh2_d;
            ch0_q       <= ch0_d;
            ch1_q       <= ch1_d;
            ch2_q       <= ch2_d;
            ch3_q       <= ch3_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Framing FSM: slot capture, frame commit and early-SOF handling.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        sh0_d       = sh0_q;
        sh1_d       = sh1_q;
        sh2_d       = sh2_q;
        ch0_d       = ch0_q;
        ch1_d       = ch1_q;
        ch2_d       = ch2_q;
        ch3_d       = ch3_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            HUNT: begin
                // Non-SOF words while hunting are silently dropped.
                if (in_valid && in_sof) begin
                    sh0_d   = in_data;
                    slot_d  = 2'd1;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (in_valid) begin
                    if (in_sof) begin
                        // Early SOF restarts the frame with this word as slot 0.
                        frame_err_d = 1'b1;
                        sh0_d       = in_data;
                        slot_d      = 2'd1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end else begin
                        case (slot_q)
                            2'd1: begin
                                sh1_d  = in_data;
                                slot_d = 2'd2;
                            end
                            2'd2: begin
                                sh2_d  = in_data;
                                slot_d = 2'd3;
                            end
                            2'd3: begin
                                ch0_d       = sh0_q;
                                ch1_d       = sh1_q;
                                ch2_d       = sh2_q;
                                ch3_d       = in_data;
                                out_valid_d = 1'b1;
                                slot_d      = 2'd0;
                                state_d     = HUNT;
                            end
                            default: begin
                                // Slot 0 is never held in RECV; fall back to hunting.
                                slot_d  = 2'd0;
                                state_d = HUNT;
                            end
                        endcase
                    end
                end
            end
            default: begin
                state_d = HUNT;
                slot_d  = 2'd0;
            end
        endcase
    end

    assign ch0       = ch0_q;
    assign ch1       = ch1_q;
    assign ch2       = ch2_q;
    assign ch3       = ch3_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: a vector table of per-cycle inputs with
// hand-computed post-edge outputs, plus an error-counter saturation sequence.
module tb_tdm_demux4;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_sof;
    logic [W-1:0] in_data;
    logic [W-1:0] ch0, ch1, ch2, ch3;
    logic         out_valid;
    logic         frame_err;
    logic [7:0]   err_cnt;

    int checks = 0;
    int errors = 0;

    tdm_demux4 #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .ch0       (ch0),
        .ch1       (ch1),
        .ch2       (ch2),
        .ch3       (ch3),
        .out_valid (out_valid),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       v;
        logic       s;
        logic [7:0] d;
        logic [7:0] e0, e1, e2, e3;
        logic       eov;
        logic       efe;
        logic [7:0] ecnt;
    } vec_t;

    vec_t vq[$];

    // Expected channel/counter values attached to the next pushed vectors.
    logic [7:0] x0, x1, x2, x3, xcnt;

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic setch(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        x0 = a; x1 = b; x2 = c; x3 = d;
    endtask

    task automatic add(input logic r, input logic v, input logic s,
                       input logic [7:0] d, input logic ov, input logic fe);
        vec_t t;
        t.r = r; t.v = v; t.s = s; t.d = d;
        t.e0 = x0; t.e1 = x1; t.e2 = x2; t.e3 = x3;
        t.eov = ov; t.efe = fe; t.ecnt = xcnt;
        vq.push_back(t);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic drive(input logic r, input logic v, input logic s, input logic [7:0] d);
        rst = r; in_valid = v; in_sof = s; in_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        setch(8'h00, 8'h00, 8'h00, 8'h00);
        xcnt = 8'h00;

        // Reset, then a gapless frame A1..D4.
        add(1, 0, 0, 8'h00, 0, 0);
        add(0, 1, 1, 8'hA1, 0, 0);
        add(0, 1, 0, 8'hB2, 0, 0);
        add(0, 1, 0, 8'hC3, 0, 0);
        setch(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        add(0, 1, 0, 8'hD4, 1, 0);
        idle(1);

        // Back-to-back frames; the second SOF follows a commit directly.
        add(0, 1, 1, 8'h01, 0, 0);
        add(0, 1, 0, 8'h02, 0, 0);
        add(0, 1, 0, 8'h03, 0, 0);
        setch(8'h01, 8'h02, 8'h03, 8'h04);
        add(0, 1, 0, 8'h04, 1, 0);
        add(0, 1, 1, 8'h11, 0, 0);
        add(0, 1, 0, 8'h12, 0, 0);
        add(0, 1, 0, 8'h13, 0, 0);
        setch(8'h11, 8'h12, 8'h13, 8'h14);
        add(0, 1, 0, 8'h14, 1, 0);
        idle(1);

        // Frame with gaps of 0, 3 and 7 idle cycles between slots.
        add(0, 1, 1, 8'h21, 0, 0);
        add(0, 1, 0, 8'h22, 0, 0);
        idle(3);
        add(0, 1, 0, 8'h23, 0, 0);
        idle(7);
        setch(8'h21, 8'h22, 8'h23, 8'h24);
        add(0, 1, 0, 8'h24, 1, 0);
        idle(2);

        // Early SOF aborts 0x10/0x20; channels keep the old frame until 0x60.
        add(0, 1, 1, 8'h10, 0, 0);
        add(0, 1, 0, 8'h20, 0, 0);
        xcnt = 8'd1;
        add(0, 1, 1, 8'h30, 0, 1);
        add(0, 1, 0, 8'h40, 0, 0);
        add(0, 1, 0, 8'h50, 0, 0);
        setch(8'h30, 8'h40, 8'h50, 8'h60);
        add(0, 1, 0, 8'h60, 1, 0);
        idle(1);

        // Reset wins over a valid SOF on the same edge; stray words ignored.
        setch(8'h00, 8'h00, 8'h00, 8'h00);
        xcnt = 8'd0;
        add(1, 1, 1, 8'h77, 0, 0);
        add(0, 1, 0, 8'hEE, 0, 0);
        add(0, 1, 0, 8'hEE, 0, 0);
        add(0, 1, 0, 8'hEE, 0, 0);
        add(0, 1, 1, 8'h5A, 0, 0);
        add(0, 1, 0, 8'h6B, 0, 0);
        add(0, 1, 0, 8'h7C, 0, 0);
        setch(8'h5A, 8'h6B, 8'h7C, 8'h8D);
        add(0, 1, 0, 8'h8D, 1, 0);

        // Reset after slot 2; following non-SOF words must not commit.
        add(0, 1, 1, 8'h91, 0, 0);
        add(0, 1, 0, 8'h92, 0, 0);
        add(0, 1, 0, 8'h93, 0, 0);
        setch(8'h00, 8'h00, 8'h00, 8'h00);
        add(1, 1, 0, 8'h94, 0, 0);
        add(0, 1, 0, 8'h94, 0, 0);
        add(0, 1, 0, 8'h95, 0, 0);
        add(0, 1, 0, 8'h96, 0, 0);
        add(0, 1, 0, 8'h97, 0, 0);

        foreach (vq[i]) begin
            drive(vq[i].r, vq[i].v, vq[i].s, vq[i].d);
            check("ch0", i, ch0, vq[i].e0);
            check("ch1", i, ch1, vq[i].e1);
            check("ch2", i, ch2, vq[i].e2);
            check("ch3", i, ch3, vq[i].e3);
            check("out_valid", i, out_valid, vq[i].eov);
            check("frame_err", i, frame_err, vq[i].efe);
            check("err_cnt", i, err_cnt, vq[i].ecnt);
        end

        // Saturation: one legal SOF, then 300 early SOFs in a row.
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b1, 8'hC0);
        check("sat_first_err", 0, frame_err, 1'b0);
        check("sat_first_cnt", 0, err_cnt, 8'd0);
        for (int k = 1; k <= 300; k++) begin
            drive(1'b0, 1'b1, 1'b1, 8'(k));
            check("sat_err", k, frame_err, 1'b1);
            check("sat_ov", k, out_valid, 1'b0);
            check("sat_cnt", k, err_cnt, (k > 255) ? 8'd255 : 8'(k));
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("sat_idle_err", 0, frame_err, 1'b0);
        check("sat_idle_cnt", 0, err_cnt, 8'd255);

        // A frame still completes after saturation; channels keep the last SOF word.
        drive(1'b0, 1'b1, 1'b0, 8'hD1);
        drive(1'b0, 1'b1, 1'b0, 8'hD2);
        drive(1'b0, 1'b1, 1'b0, 8'hD3);
        check("sat_commit_ov", 0, out_valid, 1'b1);
        check("sat_commit_ch0", 0, ch0, 8'h2C);
        check("sat_commit_ch3", 0, ch3, 8'hD3);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        check("sat_reset_cnt", 0, err_cnt, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
